// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads the combinational ROM and queues
// {pc, instr, fault} entries in a 2-deep buffer towards decode.
module imem_fetch_ctrl #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter int unsigned              MEM_SIZE      = 512,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  output logic [ADDRESS_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0]    instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic                     out_fault,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc
);

  typedef enum logic [1:0] {StIdle, StRun, StFault} state_e;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    instr;
    logic                     fault;
  } entry_t;

  // One extra bit so MEM_SIZE*4 == 2^ADDRESS_WIDTH is still representable.
  localparam logic [ADDRESS_WIDTH:0]   MemLimit       = (ADDRESS_WIDTH + 1)'(MEM_SIZE) << 2;
  localparam logic [ADDRESS_WIDTH-1:0] ResetPcAligned = {RESET_PC[ADDRESS_WIDTH-1:2], 2'b00};

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]               count_q, count_d;
  entry_t                   ent_q [2];
  entry_t                   ent_d [2];
  entry_t                   new_ent;

  logic pop, can_push, in_range, push, push_fault;
  logic unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign pop      = (count_q != 2'd0) & out_ready;
  assign can_push = (count_q != 2'd2) | pop;
  assign in_range = {1'b0, pc_q} < MemLimit;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = fetch_en ? StRun : StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (fetch_en) state_d = StRun;
        StRun: begin
          if (!fetch_en) begin
            state_d = StIdle;
          end else if (push_fault) begin
            state_d = StFault;
          end
        end
        StFault: state_d = StFault;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: whether this cycle pushes, and whether the push is a fault entry
  always_comb begin
    push       = 1'b0;
    push_fault = 1'b0;
    if (!redirect_valid && (state_q == StRun) && fetch_en && can_push) begin
      push       = 1'b1;
      push_fault = !in_range;
    end
  end

  always_comb begin
    new_ent.pc    = pc_q;
    new_ent.instr = push_fault ? '0 : instr;
    new_ent.fault = push_fault;
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
    end else if (push && !push_fault) begin
      pc_d = pc_q + ADDRESS_WIDTH'(4);
    end
  end

  // Pop shifts entry 1 into the head; push then fills the first free slot.
  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    if (redirect_valid) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        ent_d[0] = ent_q[1];
        count_d  = count_q - 2'd1;
      end
      if (push) begin
        if (count_d == 2'd0) begin
          ent_d[0] = new_ent;
        end else begin
          ent_d[1] = new_ent;
        end
        count_d = count_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= ResetPcAligned;
      count_q  <= 2'd0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
    end
  end

  assign instr_addr = pc_q;
  assign out_valid  = (count_q != 2'd0);
  assign out_pc     = ent_q[0].pc;
  assign out_instr  = ent_q[0].instr;
  assign out_fault  = ent_q[0].fault;

endmodule
